// File: rtl/ball_pkg.sv
// Shared types and geometry defaults for the ball kinematics and collision path.
package ball_pkg;

    localparam int unsigned DEF_BIT_WIDTH   = 10;
    localparam int unsigned DEF_BALL_RADIUS = 5;
    localparam int unsigned DEF_FLOOR_Y     = 479;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_MOVING   = 2'd1,
        ST_LOST     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    // One bit per axis: 0 = increasing coordinate, 1 = decreasing.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/ball_motion_if.sv
// Frame, serve and collision inputs plus ball/game-state outputs of ball_motion.
interface ball_motion_if #(
    parameter int unsigned BIT_WIDTH = ball_pkg::DEF_BIT_WIDTH
);
    logic                 frameTick;
    logic                 serve;
    logic [BIT_WIDTH-1:0] paddleX;
    logic                 ballTouchingPaddle;
    logic                 ballTouchingFloor;
    logic [BIT_WIDTH-1:0] ballX;
    logic [BIT_WIDTH-1:0] ballY;
    logic [1:0]           livesLeft;
    logic [1:0]           state;
    logic                 gameOver;

    modport master (
        output frameTick, serve, paddleX, ballTouchingPaddle, ballTouchingFloor,
        input  ballX, ballY, livesLeft, state, gameOver
    );

    modport slave (
        input  frameTick, serve, paddleX, ballTouchingPaddle, ballTouchingFloor,
        output ballX, ballY, livesLeft, state, gameOver
    );
endinterface

// File: rtl/ball_axis_step.sv
// Next coordinate and direction for one axis: step, optional paddle-crossing clamp,
// then low/high wall clamp with direction update.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int unsigned W       = DEF_BIT_WIDTH,
    parameter int unsigned STEP    = 2,
    parameter int unsigned LO      = DEF_BALL_RADIUS,
    parameter int unsigned HI      = 634,
    parameter bit          HI_FLIP = 1'b1
) (
    input  logic [W-1:0] cur_i,
    input  dir_e         dir_i,
    input  logic         paddle_en_i,
    input  logic [W-1:0] paddle_i,
    output logic [W-1:0] next_c_o,
    output dir_e         dir_c_o
);
    localparam int unsigned SW = W + 1;

    logic signed [SW-1:0] cur_s, pad_s, step_s, lo_s, hi_s, nxt_s;
    logic                 crosses;

    assign cur_s  = $signed({1'b0, cur_i});
    assign pad_s  = $signed({1'b0, paddle_i});
    assign step_s = $signed(SW'(STEP));
    assign lo_s   = $signed(SW'(LO));
    assign hi_s   = $signed(SW'(HI));

    always_comb begin
        dir_c_o = dir_i;
        nxt_s   = (dir_i == DIR_NEG) ? (cur_s - step_s) : (cur_s + step_s);
        // Land on the paddle column instead of jumping over it.
        crosses = (dir_i == DIR_POS) ? (pad_s > cur_s && pad_s < nxt_s)
                                     : (pad_s < cur_s && pad_s > nxt_s);
        if (paddle_en_i && crosses) begin
            nxt_s = pad_s;
        end
        if (nxt_s < lo_s) begin
            nxt_s   = lo_s;
            dir_c_o = DIR_POS;
        end else if (nxt_s > hi_s) begin
            nxt_s = hi_s;
            if (HI_FLIP) begin
                dir_c_o = DIR_NEG;
            end
        end
        next_c_o = nxt_s[W-1:0];
    end

endmodule

// File: rtl/ball_motion.sv
// Game-state FSM and per-frame ball kinematics feeding collisionDetection.
module ball_motion
    import ball_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int unsigned BALL_RADIUS = DEF_BALL_RADIUS,
    parameter int unsigned FLOOR_Y     = DEF_FLOOR_Y,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned START_X     = 320,
    parameter int unsigned START_Y     = 240,
    parameter int unsigned STEP        = 2,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned LOST_TICKS  = 30
) (
    input logic          clk,
    input logic          rst_n,
    ball_motion_if.slave bus
);
    localparam int unsigned X_HI     = SCREEN_W - 1 - BALL_RADIUS;
    localparam int unsigned Y_HI     = FLOOR_Y + BALL_RADIUS;
    localparam int unsigned CNT_W    = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;
    localparam int unsigned LAST_CNT = LOST_TICKS - 1;

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d, x_step, y_step;
    dir_e                 dirx_q, dirx_d, diry_q, diry_d, dirx_in, dirx_step, diry_step;
    logic [1:0]           lives_q, lives_d;
    logic [CNT_W-1:0]     lost_cnt_q, lost_cnt_d;
    logic                 hit_q, hit_d;
    logic                 game_over_q, game_over_d;

    // First tick of a paddle contact reverses X before the step is taken.
    assign dirx_in = (bus.ballTouchingPaddle && !hit_q) ? dir_e'(~dirx_q) : dirx_q;

    ball_axis_step #(
        .W(BIT_WIDTH), .STEP(STEP), .LO(BALL_RADIUS), .HI(X_HI), .HI_FLIP(1'b1)
    ) u_axis_x (
        .cur_i(x_q), .dir_i(dirx_in), .paddle_en_i(1'b1), .paddle_i(bus.paddleX),
        .next_c_o(x_step), .dir_c_o(dirx_step)
    );

    ball_axis_step #(
        .W(BIT_WIDTH), .STEP(STEP), .LO(BALL_RADIUS), .HI(Y_HI), .HI_FLIP(1'b0)
    ) u_axis_y (
        .cur_i(y_q), .dir_i(diry_q), .paddle_en_i(1'b0), .paddle_i('0),
        .next_c_o(y_step), .dir_c_o(diry_step)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dirx_d     = dirx_q;
        diry_d     = diry_q;
        lives_d    = lives_q;
        lost_cnt_d = lost_cnt_q;
        hit_d      = hit_q;
        case (state_q)
            ST_SERVE: begin
                x_d = BIT_WIDTH'(START_X);
                y_d = BIT_WIDTH'(START_Y);
                if (bus.serve) begin
                    state_d = ST_MOVING;
                end
            end
            ST_MOVING: begin
                if (bus.frameTick) begin
                    if (bus.ballTouchingFloor) begin
                        state_d = ST_LOST;
                        lives_d = lives_q - 2'd1;
                        hit_d   = 1'b0;
                    end else begin
                        hit_d  = bus.ballTouchingPaddle;
                        x_d    = x_step;
                        y_d    = y_step;
                        dirx_d = dirx_step;
                        diry_d = diry_step;
                    end
                end
            end
            ST_LOST: begin
                if (bus.frameTick) begin
                    if (lost_cnt_q == CNT_W'(LAST_CNT)) begin
                        lost_cnt_d = '0;
                        x_d        = BIT_WIDTH'(START_X);
                        y_d        = BIT_WIDTH'(START_Y);
                        dirx_d     = DIR_POS;
                        diry_d     = DIR_POS;
                        state_d    = (lives_q != 2'd0) ? ST_SERVE : ST_GAMEOVER;
                    end else begin
                        lost_cnt_d = lost_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                x_d = BIT_WIDTH'(START_X);
                y_d = BIT_WIDTH'(START_Y);
                if (bus.serve) begin
                    lives_d = 2'(LIVES);
                    state_d = ST_SERVE;
                end
            end
        endcase
        game_over_d = (state_d == ST_GAMEOVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SERVE;
            x_q         <= BIT_WIDTH'(START_X);
            y_q         <= BIT_WIDTH'(START_Y);
            dirx_q      <= DIR_POS;
            diry_q      <= DIR_POS;
            lives_q     <= 2'(LIVES);
            lost_cnt_q  <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dirx_q      <= dirx_d;
            diry_q      <= diry_d;
            lives_q     <= lives_d;
            lost_cnt_q  <= lost_cnt_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.ballX     = x_q;
    assign bus.ballY     = y_q;
    assign bus.livesLeft = lives_q;
    assign bus.state     = state_q;
    assign bus.gameOver  = game_over_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve, stepping, paddle/wall/floor handling, lives and reset.
module tb_ball_motion;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [24:0] want;

    ball_motion_if #(.BIT_WIDTH(10)) bus ();

    ball_motion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ballX, ballY, state, livesLeft, gameOver}
    function automatic logic [24:0] pk(input int x, input int y, input int st, input int lv, input int go);
        return {10'(x), 10'(y), 2'(st), 2'(lv), 1'(go)};
    endfunction

    function automatic logic [24:0] snap();
        return {bus.ballX, bus.ballY, bus.state, bus.livesLeft, bus.gameOver};
    endfunction

    task automatic tick(input logic p, input logic f);
        @(negedge clk);
        bus.frameTick          = 1'b1;
        bus.ballTouchingPaddle = p;
        bus.ballTouchingFloor  = f;
        @(negedge clk);
        bus.frameTick          = 1'b0;
        bus.ballTouchingPaddle = 1'b0;
        bus.ballTouchingFloor  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic serve_pulse();
        @(negedge clk);
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
    endtask

    task automatic test_reset();
        bus.frameTick = 0; bus.serve = 0; bus.paddleX = '0;
        bus.ballTouchingPaddle = 0; bus.ballTouchingFloor = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        want = pk(320, 240, 0, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL reset_state: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(320, 240, 0, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL serve_hold_on_tick: got %h want %h", snap(), want); end
    endtask

    task automatic test_serve_move();
        serve_pulse();
        want = pk(320, 240, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL serve_to_moving: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(322, 242, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL first_step: got %h want %h", snap(), want); end
        ticks(9);
        want = pk(340, 260, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL ten_steps: got %h want %h", snap(), want); end
        serve_pulse();
        want = pk(340, 260, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL serve_ignored_moving: got %h want %h", snap(), want); end
    endtask

    task automatic test_paddle();
        bus.paddleX = 10'd341;
        tick(1'b0, 1'b0);
        want = pk(341, 262, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL paddle_cross_clamp: got %h want %h", snap(), want); end
        tick(1'b1, 1'b0);
        want = pk(339, 264, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL paddle_reflect: got %h want %h", snap(), want); end
        tick(1'b1, 1'b0);
        want = pk(337, 266, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL paddle_no_second_flip: got %h want %h", snap(), want); end
        tick(1'b1, 1'b0);
        want = pk(335, 268, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL paddle_still_latched: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(333, 270, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL latch_clear_tick: got %h want %h", snap(), want); end
        tick(1'b1, 1'b0);
        want = pk(335, 272, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL paddle_reflect_again: got %h want %h", snap(), want); end
        bus.paddleX = '0;
    endtask

    task automatic test_right_wall();
        ticks(149);
        want = pk(633, 484, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL approach_wall_floor_clamp: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(634, 484, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL right_wall_clamp: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(632, 484, 1, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL right_wall_reflect: got %h want %h", snap(), want); end
    endtask

    task automatic test_floor_and_lost();
        tick(1'b1, 1'b1);
        want = pk(632, 484, 2, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL floor_beats_paddle: got %h want %h", snap(), want); end
        ticks(10);
        serve_pulse();
        want = pk(632, 484, 2, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL serve_ignored_lost: got %h want %h", snap(), want); end
        ticks(19);
        want = pk(632, 484, 2, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL lost_29_ticks: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(320, 240, 0, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL lost_to_serve: got %h want %h", snap(), want); end
    endtask

    task automatic test_same_cycle_and_gameover();
        @(negedge clk);
        bus.serve = 1'b1; bus.frameTick = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0; bus.frameTick = 1'b0;
        want = pk(320, 240, 1, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL serve_with_tick: got %h want %h", snap(), want); end
        tick(1'b0, 1'b1);
        want = pk(320, 240, 2, 1, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL second_life_lost: got %h want %h", snap(), want); end
        ticks(30);
        serve_pulse();
        tick(1'b0, 1'b1);
        want = pk(320, 240, 2, 0, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL last_life_lost: got %h want %h", snap(), want); end
        ticks(30);
        want = pk(320, 240, 3, 0, 1); checks++;
        if (snap() !== want) begin failures++; $display("FAIL game_over: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(320, 240, 3, 0, 1); checks++;
        if (snap() !== want) begin failures++; $display("FAIL game_over_hold: got %h want %h", snap(), want); end
        serve_pulse();
        want = pk(320, 240, 0, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL restart_from_gameover: got %h want %h", snap(), want); end
    endtask

    task automatic test_reset_mid_lost();
        serve_pulse();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        ticks(12);
        want = pk(322, 242, 2, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL lost_before_reset: got %h want %h", snap(), want); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        want = pk(320, 240, 0, 3, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL async_reset_mid_lost: got %h want %h", snap(), want); end
        @(negedge clk);
        rst_n = 1'b1;
        serve_pulse();
        tick(1'b0, 1'b1);
        ticks(29);
        want = pk(320, 240, 2, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL lost_count_cleared: got %h want %h", snap(), want); end
        tick(1'b0, 1'b0);
        want = pk(320, 240, 0, 2, 0); checks++;
        if (snap() !== want) begin failures++; $display("FAIL lost_full_length: got %h want %h", snap(), want); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_serve_move();
        test_paddle();
        test_right_wall();
        test_floor_and_lost();
        test_same_cycle_and_gameover();
        test_reset_mid_lost();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
